// File: rtl/motor_ramp_ctrl_if.sv
// motor_ramp_ctrl_if
// Groups the navigation mode input and the drive outputs of motor_ramp_ctrl.
//   mode       : 5-bit navigation mode (driven by the master)
//   left_duty  : applied left-wheel duty
//   right_duty : applied right-wheel duty
//   l_IN, r_IN : H-bridge direction pairs, 2'b10 forward, 2'b01 reverse
//   settled    : both wheels have reached their target duty and direction
// The master modport belongs to whoever issues modes; the slave modport is
// the ramp controller itself.
interface motor_ramp_ctrl_if #(
  parameter int DUTY_W = 10
);
  logic [4:0]        mode;
  logic [DUTY_W-1:0] left_duty;
  logic [DUTY_W-1:0] right_duty;
  logic [1:0]        l_IN;
  logic [1:0]        r_IN;
  logic              settled;

  modport master (
    output mode,
    input  left_duty, right_duty, l_IN, r_IN, settled
  );

  modport slave (
    input  mode,
    output left_duty, right_duty, l_IN, r_IN, settled
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl
// Decodes the navigation mode into per-wheel target duty/direction and slews
// each wheel's applied duty toward its target once per ramp tick. A wheel that
// must change direction first brakes to zero, dwells DEAD_TICKS ticks, flips,
// then ramps up again. STOP/ERROR drop both duties to zero on the next edge.
// Ports:
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : motor_ramp_ctrl_if slave (mode in; duties, directions, settled out)
// Wheel index 0 is left, 1 is right.
module motor_ramp_ctrl #(
  parameter int DUTY_W     = 10,
  parameter int FAST       = 750,
  parameter int SLOW       = 700,
  parameter int TRIM       = 5,
  parameter int RAMP_STEP  = 25,
  parameter int RAMP_DIV   = 100000,
  parameter int DEAD_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  motor_ramp_ctrl_if.slave    bus
);

  localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX  = DEAD_W'(DEAD_TICKS);
  localparam logic [DUTY_W:0]   STEP_WIDE = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] STEP_N    = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] FAST_N    = DUTY_W'(FAST);
  localparam logic [DUTY_W-1:0] SLOW_N    = DUTY_W'(SLOW);
  localparam logic [DUTY_W-1:0] TRIMMED_N = DUTY_W'(FAST - TRIM);

  localparam logic [4:0] MODE_IDLE         = 5'd0;
  localparam logic [4:0] MODE_START        = 5'd1;
  localparam logic [4:0] MODE_COUNT        = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT     = 5'd3;
  localparam logic [4:0] MODE_CHOOSE       = 5'd4;
  localparam logic [4:0] MODE_LEFT         = 5'd5;
  localparam logic [4:0] MODE_RIGHT        = 5'd6;
  localparam logic [4:0] MODE_BACK         = 5'd7;
  localparam logic [4:0] MODE_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] MODE_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] MODE_STOP         = 5'd30;
  localparam logic [4:0] MODE_ERROR        = 5'd31;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } wheelState_e;

  logic [CNT_W-1:0]  tickCnt_q, tickCnt_d;
  logic              tick;
  logic              emergency;

  logic [DUTY_W-1:0] tgtDuty_q [2];
  logic [DUTY_W-1:0] tgtDuty_d [2];
  logic              tgtFwd_q  [2];
  logic              tgtFwd_d  [2];

  logic [DUTY_W-1:0] duty_q    [2];
  logic [DUTY_W-1:0] duty_d    [2];
  logic              fwd_q     [2];
  logic              fwd_d     [2];
  wheelState_e       state_q   [2];
  wheelState_e       state_d   [2];
  logic [DEAD_W-1:0] dead_q    [2];
  logic [DEAD_W-1:0] dead_d    [2];

  logic              settled_q, settled_d;

  // Clamp a duty gap (computed one bit wider so it never wraps) to the
  // per-tick step; the result always fits in DUTY_W bits.
  function automatic logic [DUTY_W-1:0] stepOf(input logic [DUTY_W:0] gap);
    return (gap < STEP_WIDE) ? gap[DUTY_W-1:0] : STEP_N;
  endfunction

  // Free-running ramp tick; mode changes deliberately never disturb it.
  always_comb begin
    tick      = (tickCnt_q == CNT_MAX);
    tickCnt_d = tick ? '0 : tickCnt_q + CNT_W'(1);
    emergency = (bus.mode == MODE_STOP) || (bus.mode == MODE_ERROR);
  end

  // Mode decode into the target registers. Unknown codes keep the previous
  // targets; an emergency zeroes target duty but keeps target direction.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      tgtDuty_d[w] = tgtDuty_q[w];
      tgtFwd_d[w]  = tgtFwd_q[w];
    end
    case (bus.mode)
      MODE_IDLE, MODE_START, MODE_COUNT: begin
        tgtDuty_d[0] = '0;        tgtDuty_d[1] = '0;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_STRAIGHT: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = TRIMMED_N;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_CHOOSE: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = FAST_N;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_LEFT: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = FAST_N;
        tgtFwd_d[0]  = 1'b0;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_RIGHT: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = FAST_N;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b0;
      end
      MODE_BACK: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = TRIMMED_N;
        tgtFwd_d[0]  = 1'b0;      tgtFwd_d[1]  = 1'b0;
      end
      MODE_LITTLE_LEFT: begin
        tgtDuty_d[0] = SLOW_N;    tgtDuty_d[1] = FAST_N;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_LITTLE_RIGHT: begin
        tgtDuty_d[0] = FAST_N;    tgtDuty_d[1] = SLOW_N;
        tgtFwd_d[0]  = 1'b1;      tgtFwd_d[1]  = 1'b1;
      end
      MODE_STOP, MODE_ERROR: begin
        tgtDuty_d[0] = '0;        tgtDuty_d[1] = '0;
      end
      default: ;
    endcase
  end

  // Per-wheel ramp FSM next state. Reversals go TRACK -> BRAKE -> DEAD ->
  // flip; a target direction that reverts mid-way drops back to TRACK with
  // the duty left where it is for that tick. The brake tick that lands on
  // zero already moves to DEAD so the dwell count starts immediately.
  always_comb begin
    settled_d = 1'b1;
    for (int w = 0; w < 2; w++) begin
      duty_d[w]  = duty_q[w];
      fwd_d[w]   = fwd_q[w];
      state_d[w] = state_q[w];
      dead_d[w]  = dead_q[w];
      if (emergency) begin
        duty_d[w]  = '0;
        state_d[w] = TRACK;
        dead_d[w]  = '0;
      end else if (tick) begin
        unique case (state_q[w])
          TRACK: begin
            if (tgtFwd_q[w] == fwd_q[w]) begin
              if (tgtDuty_q[w] >= duty_q[w])
                duty_d[w] = duty_q[w] + stepOf({1'b0, tgtDuty_q[w]} - {1'b0, duty_q[w]});
              else
                duty_d[w] = duty_q[w] - stepOf({1'b0, duty_q[w]} - {1'b0, tgtDuty_q[w]});
            end else begin
              duty_d[w]  = duty_q[w] - stepOf({1'b0, duty_q[w]});
              state_d[w] = (duty_d[w] == '0) ? DEAD : BRAKE;
              dead_d[w]  = '0;
            end
          end
          BRAKE: begin
            if (tgtFwd_q[w] == fwd_q[w]) begin
              state_d[w] = TRACK;
            end else begin
              duty_d[w] = duty_q[w] - stepOf({1'b0, duty_q[w]});
              if (duty_d[w] == '0) begin
                state_d[w] = DEAD;
                dead_d[w]  = '0;
              end
            end
          end
          DEAD: begin
            if (tgtFwd_q[w] == fwd_q[w]) begin
              state_d[w] = TRACK;
            end else if (dead_q[w] == DEAD_MAX) begin
              fwd_d[w]   = ~fwd_q[w];
              state_d[w] = TRACK;
            end else begin
              dead_d[w] = dead_q[w] + DEAD_W'(1);
            end
          end
          default: state_d[w] = TRACK;
        endcase
      end
      if ((duty_d[w] != tgtDuty_d[w]) || (fwd_d[w] != tgtFwd_d[w]) || (state_d[w] != TRACK))
        settled_d = 1'b0;
    end
  end

  // All state registers; reset parks both wheels stopped, forward and settled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tickCnt_q <= '0;
      settled_q <= 1'b1;
      for (int w = 0; w < 2; w++) begin
        tgtDuty_q[w] <= '0;
        tgtFwd_q[w]  <= 1'b1;
        duty_q[w]    <= '0;
        fwd_q[w]     <= 1'b1;
        state_q[w]   <= TRACK;
        dead_q[w]    <= '0;
      end
    end else begin
      tickCnt_q <= tickCnt_d;
      settled_q <= settled_d;
      for (int w = 0; w < 2; w++) begin
        tgtDuty_q[w] <= tgtDuty_d[w];
        tgtFwd_q[w]  <= tgtFwd_d[w];
        duty_q[w]    <= duty_d[w];
        fwd_q[w]     <= fwd_d[w];
        state_q[w]   <= state_d[w];
        dead_q[w]    <= dead_d[w];
      end
    end
  end

  assign bus.left_duty  = duty_q[0];
  assign bus.right_duty = duty_q[1];
  assign bus.l_IN       = fwd_q[0] ? 2'b10 : 2'b01;
  assign bus.r_IN       = fwd_q[1] ? 2'b10 : 2'b01;
  assign bus.settled    = settled_q;

endmodule

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Parametrised successor of the two-motor mode-to-drive controller. Decodes the 5-bit navigation `mode` into per-wheel target duty and direction, then slews each wheel's duty toward its target at a programmable rate. A wheel is never reversed while it is moving: it ramps to zero, waits a dead time, flips direction, then ramps up. `STOP`/`ERROR` cut drive immediately. The duty outputs feed the existing PWM generators in the top level.

## Interface
- `DUTY_W`, 10: duty width, in bits.
- `FAST`, 750: cruise duty.
- `SLOW`, 700: inner-wheel duty for the little-turn modes.
- `TRIM`, 5: right-wheel reduction applied in `STRAIGHT` and `BACK`.
- `RAMP_STEP`, 25: maximum duty change per ramp tick. Must be >0.
- `RAMP_DIV`, 100000: clock cycles per ramp tick. Must be ≥1.
- `DEAD_TICKS`, 4: ramp ticks held at zero before a direction flip. 0 means flip on the next tick.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-low reset.
- `mode` in 5: navigation mode. Encodings: `IDLE`=0, `START`=1, `COUNT`=2, `STRAIGHT`=3, `CHOOSE`=4, `LEFT`=5, `RIGHT`=6, `BACK`=7, `LITTLE_LEFT`=8, `LITTLE_RIGHT`=9, `STOP`=30, `ERROR`=31.
- `left_duty` out `DUTY_W`: applied left duty.
- `right_duty` out `DUTY_W`: applied right duty.
- `l_IN` out 2: left H-bridge direction. 2'b10 is forward, 2'b01 is reverse.
- `r_IN` out 2: right H-bridge direction, same encoding.
- `settled` out 1: high when both wheels' applied duty and direction equal their targets.

## Operation
- Target decode: `mode` is registered each cycle into per-wheel target duty/direction registers (tL/dL, tR/dR).
  - `IDLE`, `START`, `COUNT`: both 0, forward.
  - `STRAIGHT`: L=`FAST`, R=`FAST-TRIM`, both forward.
  - `CHOOSE`: both `FAST`, forward.
  - `LEFT`: both `FAST`; L reverse, R forward.
  - `RIGHT`: both `FAST`; L forward, R reverse.
  - `BACK`: L=`FAST`, R=`FAST-TRIM`, both reverse.
  - `LITTLE_LEFT`: L=`SLOW`, R=`FAST`, forward.
  - `LITTLE_RIGHT`: L=`FAST`, R=`SLOW`, forward.
  - Any other code: targets hold their previous value.
- Tick generator: free-running counter 0..`RAMP_DIV`-1, width `$clog2(RAMP_DIV)`, min 1. `tick` is high for the one cycle when the count equals `RAMP_DIV`-1, then the counter wraps to 0. Mode changes never reset the counter.
- Per-wheel FSM. States are `TRACK`, `BRAKE`, `DEAD`. All updates below occur only on `tick`.
  - `TRACK`, target direction equals applied direction: duty moves toward target by `min(RAMP_STEP, |target-duty|)`. No overshoot, no wrap; the arithmetic uses `DUTY_W+1` bits.
  - `TRACK`, target direction differs: go to `BRAKE` and apply this tick's decrement.
  - `BRAKE`: duty -= `min(RAMP_STEP, duty)`. When duty reaches 0, go to `DEAD` with dead count = 0.
    - If the target direction returns to the applied direction mid-brake, go to `TRACK`.
  - `DEAD`: duty stays 0, dead count increments. Once it has counted `DEAD_TICKS` ticks, the next tick flips the direction and enters `TRACK` (no duty change on that tick).
    - A target-direction revert during `DEAD` returns to `TRACK` without a flip.
  - Zero-target modes select forward, so a reversing wheel commanded to `IDLE` brakes, dwells, then flips to forward.
- Emergency, `mode` = `STOP` or `ERROR`, taken directly from the port, not the registered target:
  - On the next edge both duties become 0, both FSMs go to `TRACK`, and dead counts clear.
  - Directions are unchanged and targets become 0.
  - While emergency persists, there is no ramping.
- `settled` = (L duty==tL && L dir==dL && L state==`TRACK`) && (same for R). Registered.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - `left_duty` = `right_duty` = 0, `l_IN` = `r_IN` = 2'b10.
  - Tick counter 0, targets 0/forward, both FSMs `TRACK`, `settled` = 1.
- Latency, `mode` to target registers: 1 cycle. Target to first duty change: up to `RAMP_DIV` cycles, at the next tick.
- Emergency: duty is 0 at the first edge after `mode` becomes 30/31. Emergency dominates a coincident tick.
- Ramp 0→`FAST` at defaults: ceil(750/25) = 30 ticks.
- Full reversal from `FAST`: 30 brake ticks + `DEAD_TICKS` + 1 flip tick + 30 ramp ticks.
- Reset asserted mid-ramp or mid-dead: reset dominates everything.
- Direction outputs change only on a tick while the wheel's duty is 0. Invariant: duty ≠ 0 is never present on the same cycle as a direction change.

## Test plan
Bench parameters: `RAMP_DIV`=4, `RAMP_STEP`=250, `DEAD_TICKS`=2 unless stated.
- Reset, then hold `IDLE` → duties 0, `l_IN`/`r_IN` = 2'b10, `settled` = 1, all stable.
- `STRAIGHT` from rest → L steps 250, 500, 750; R steps 250, 500, 745 (last step clamped to 245), one step every 4 cycles. `settled` rises after the 3rd tick.
- `STRAIGHT` settled, then `BACK` → both brake to 0 over 3 ticks and stay 0 for 2 ticks. Flip tick: `l_IN`/`r_IN` = 2'b01. Then ramp back to 750/745. Check duty is 0 at the flip.
- Mid-ramp (L=500), apply `STOP` → next edge both duties 0, directions unchanged. Release to `CHOOSE` → ramp resumes from 0.
- `LEFT` then back to `CHOOSE` during L's `DEAD` → L returns to `TRACK` forward with no flip, then ramps to 750. `l_IN` stays 2'b10 throughout.
- Illegal `mode`=15 while in `LITTLE_RIGHT` → targets hold (750/700). `rst`=0 mid-reversal → all outputs take their reset values on that edge.
